// File: rtl/zl_ts_null_mux_pkg.sv
// Shared TS framing constants and the scheduler state type for the null-packet mux.
// The randomizer stage relies on the same sync byte, packet length and null PID.
package zl_ts_null_mux_pkg;

    localparam logic [7:0]  SYNC_BYTE     = 8'h47;
    localparam int          TS_PACKET_LEN = 188;
    localparam logic [12:0] NULL_PID      = 13'h1FFF;
    localparam logic [7:0]  NULL_FILL     = 8'hFF;
    localparam logic [7:0]  NULL_HDR3     = 8'h10;
    localparam int          CNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        S_BOUNDARY = 2'd0,
        S_SRC      = 2'd1,
        S_NULL     = 2'd2
    } state_e;

endpackage

// File: rtl/zl_ts_null_mux_null_gen.sv
// Null-packet byte lookup: maps a position inside the packet to the generated byte.
module zl_ts_null_gen
    import zl_ts_null_mux_pkg::*;
#(
    parameter logic [12:0] Null_pid  = NULL_PID,
    parameter logic [7:0]  Null_fill = NULL_FILL
) (
    input  logic [7:0] byte_count,
    output logic [7:0] null_byte
);

    // Header bytes come first; position 3 carries payload-only, adaptation field absent.
    always_comb begin
        null_byte = Null_fill;
        case (byte_count)
            8'd0:    null_byte = SYNC_BYTE;
            8'd1:    null_byte = {3'b000, Null_pid[12:8]};
            8'd2:    null_byte = Null_pid[7:0];
            8'd3:    null_byte = NULL_HDR3;
            default: null_byte = Null_fill;
        endcase
    end

endmodule

// File: rtl/zl_ts_null_mux.sv
// Packet-boundary scheduler: forwards aligned source packets or inserts null packets
// so the constant-rate modulator is never starved; a started packet always completes.
module zl_ts_null_mux
    import zl_ts_null_mux_pkg::*;
#(
    parameter int          Packet_len = TS_PACKET_LEN,
    parameter logic [12:0] Null_pid   = NULL_PID,
    parameter logic [7:0]  Null_fill  = NULL_FILL,
    parameter int          Cnt_width  = CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 null_en,
    input  logic                 data_in_req,
    output logic                 data_in_ack,
    input  logic [7:0]           data_in,
    output logic                 data_out_req,
    input  logic                 data_out_ack,
    output logic [7:0]           data_out,
    output logic [Cnt_width-1:0] src_pkt_cnt,
    output logic [Cnt_width-1:0] null_pkt_cnt,
    output logic [Cnt_width-1:0] drop_byte_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(Packet_len - 1);

    function automatic logic [Cnt_width-1:0] sat_inc(input logic [Cnt_width-1:0] v);
        if (v == {Cnt_width{1'b1}}) begin
            return v;
        end else begin
            return v + {{(Cnt_width-1){1'b0}}, 1'b1};
        end
    endfunction

    state_e               state_r;
    logic [7:0]           byte_count_r;
    logic [Cnt_width-1:0] src_cnt_r;
    logic [Cnt_width-1:0] null_cnt_r;
    logic [Cnt_width-1:0] drop_cnt_r;

    logic       out_req_s;
    logic       in_ack_s;
    logic [7:0] out_byte_s;
    logic       src_sel_s;
    logic       drop_s;
    logic       xfer_s;
    logic [7:0] null_byte_s;

    zl_ts_null_gen #(
        .Null_pid  (Null_pid),
        .Null_fill (Null_fill)
    ) u_null_gen (
        .byte_count (byte_count_r),
        .null_byte  (null_byte_s)
    );

    // Output mux and handshake; at a boundary the choice is re-made every cycle until a byte moves.
    always_comb begin
        out_req_s  = 1'b0;
        in_ack_s   = 1'b0;
        out_byte_s = 8'h00;
        src_sel_s  = 1'b0;
        drop_s     = 1'b0;
        case (state_r)
            S_BOUNDARY: begin
                if (data_in_req && (data_in == SYNC_BYTE)) begin
                    out_req_s  = 1'b1;
                    in_ack_s   = data_out_ack;
                    out_byte_s = data_in;
                    src_sel_s  = 1'b1;
                end else if (data_in_req) begin
                    in_ack_s = 1'b1;
                    drop_s   = 1'b1;
                end else if (null_en) begin
                    out_req_s  = 1'b1;
                    out_byte_s = SYNC_BYTE;
                end else begin
                    out_req_s = 1'b0;
                end
            end
            S_SRC: begin
                out_req_s  = data_in_req;
                in_ack_s   = data_in_req && data_out_ack;
                out_byte_s = data_in;
            end
            S_NULL: begin
                out_req_s  = 1'b1;
                out_byte_s = null_byte_s;
            end
            default: begin
                out_req_s = 1'b0;
            end
        endcase
    end

    assign xfer_s        = out_req_s && data_out_ack;
    assign data_out_req  = out_req_s;
    assign data_in_ack   = in_ack_s;
    assign data_out      = out_byte_s;
    assign src_pkt_cnt   = src_cnt_r;
    assign null_pkt_cnt  = null_cnt_r;
    assign drop_byte_cnt = drop_cnt_r;

    // Packet FSM, byte position and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_BOUNDARY;
            byte_count_r <= 8'd0;
            src_cnt_r    <= {Cnt_width{1'b0}};
            null_cnt_r   <= {Cnt_width{1'b0}};
            drop_cnt_r   <= {Cnt_width{1'b0}};
        end else begin
            if (drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
            case (state_r)
                S_BOUNDARY: begin
                    if (xfer_s) begin
                        state_r      <= src_sel_s ? S_SRC : S_NULL;
                        byte_count_r <= 8'd1;
                    end
                end
                S_SRC, S_NULL: begin
                    if (xfer_s) begin
                        if (byte_count_r == LAST_IDX) begin
                            byte_count_r <= 8'd0;
                            state_r      <= S_BOUNDARY;
                            if (state_r == S_SRC) begin
                                src_cnt_r <= sat_inc(src_cnt_r);
                            end else begin
                                null_cnt_r <= sat_inc(null_cnt_r);
                            end
                        end else begin
                            byte_count_r <= byte_count_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r      <= S_BOUNDARY;
                    byte_count_r <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zl_ts_null_mux.sv
// Self-checking bench for zl_ts_null_mux: directed scenarios plus randomized traffic
// compared against a packet-level reference model.
module tb_zl_ts_null_mux;

    logic        clk;
    logic        rst_n;
    logic        null_en;
    logic        data_in_req;
    logic        data_in_ack;
    logic [7:0]  data_in;
    logic        data_out_req;
    logic        data_out_ack;
    logic [7:0]  data_out;
    logic [15:0] src_pkt_cnt;
    logic [15:0] null_pkt_cnt;
    logic [15:0] drop_byte_cnt;

    int n_cmp = 0;
    int n_err = 0;

    zl_ts_null_mux dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .null_en       (null_en),
        .data_in_req   (data_in_req),
        .data_in_ack   (data_in_ack),
        .data_in       (data_in),
        .data_out_req  (data_out_req),
        .data_out_ack  (data_out_ack),
        .data_out      (data_out),
        .src_pkt_cnt   (src_pkt_cnt),
        .null_pkt_cnt  (null_pkt_cnt),
        .drop_byte_cnt (drop_byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: are we inside a packet, which kind, and how many bytes have gone out.
    bit         m_in_pkt;
    bit         m_is_null;
    int         m_pos;
    int         m_src;
    int         m_null;
    int         m_drop;
    logic [7:0] null_ref [188];
    logic       exp_req;
    logic       exp_ack;
    logic [7:0] exp_out;
    bit         exp_chk_out;
    bit         m_src_start;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_in_pkt  = 0;
        m_is_null = 0;
        m_pos     = 0;
        m_src     = 0;
        m_null    = 0;
        m_drop    = 0;
    endtask

    task automatic model_eval();
        exp_chk_out = 1;
        exp_out     = 8'h00;
        m_src_start = 0;
        if (!m_in_pkt) begin
            if (data_in_req && data_in == 8'h47) begin
                exp_req = 1'b1; exp_ack = data_out_ack; exp_out = data_in; m_src_start = 1;
            end else if (data_in_req) begin
                exp_req = 1'b0; exp_ack = 1'b1; exp_chk_out = 0;
            end else if (null_en) begin
                exp_req = 1'b1; exp_ack = 1'b0; exp_out = 8'h47;
            end else begin
                exp_req = 1'b0; exp_ack = 1'b0; exp_out = 8'h00;
            end
        end else if (!m_is_null) begin
            exp_req = data_in_req; exp_ack = data_in_req && data_out_ack;
            exp_out = data_in; exp_chk_out = data_in_req;
        end else begin
            exp_req = 1'b1; exp_ack = 1'b0; exp_out = null_ref[m_pos];
        end
    endtask

    task automatic model_commit();
        if (!m_in_pkt) begin
            if (data_in_req && data_in != 8'h47) begin
                m_drop = sat(m_drop);
            end else if (exp_req && data_out_ack) begin
                m_in_pkt = 1; m_is_null = !m_src_start; m_pos = 1;
            end
        end else if (exp_req && data_out_ack) begin
            m_pos++;
            if (m_pos == 188) begin
                m_in_pkt = 0;
                if (m_is_null) m_null = sat(m_null);
                else           m_src  = sat(m_src);
            end
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        model_eval();
    endtask

    task automatic half_b();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; null_en = 1'b0; data_in_req = 1'b0; data_in = 8'h00; data_out_ack = 1'b0;
        model_reset();
        #12;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({data_out_req, data_in_ack, data_out} !== {1'b0, 1'b0, 8'h00}) begin
            n_err++; $display("FAIL reset_out got req=%b ack=%b out=%h want 0 0 00", data_out_req, data_in_ack, data_out);
        end
        n_cmp++;
        if ({src_pkt_cnt, null_pkt_cnt, drop_byte_cnt} !== 48'd0) begin
            n_err++; $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0", src_pkt_cnt, null_pkt_cnt, drop_byte_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_src_packets();
        null_en = 1'b0; data_out_ack = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 188; i++) begin
                data_in_req = 1'b1;
                data_in     = (i == 0) ? 8'h47 : 8'(i);
                half_a();
                n_cmp++;
                if ({data_out_req, data_in_ack} !== {exp_req, exp_ack}) begin
                    n_err++; $display("FAIL src_hs p%0d b%0d got %b%b want %b%b", p, i, data_out_req, data_in_ack, exp_req, exp_ack);
                end
                n_cmp++;
                if (data_out !== 8'(i == 0 ? 8'h47 : i)) begin
                    n_err++; $display("FAIL src_byte p%0d b%0d got %h want %h", p, i, data_out, data_in);
                end
                half_b();
            end
        end
        data_in_req = 1'b0;
        n_cmp++;
        if (src_pkt_cnt !== 16'(m_src) || null_pkt_cnt !== 16'(m_null) || m_src != 2) begin
            n_err++; $display("FAIL src_cnt got src=%0d null=%0d want src=2 null=0", src_pkt_cnt, null_pkt_cnt);
        end
    endtask

    task automatic test_null_packets();
        data_in_req = 1'b0; null_en = 1'b1; data_out_ack = 1'b1;
        for (int c = 0; c < 376; c++) begin
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack, data_out} !== {exp_req, exp_ack, exp_out}) begin
                n_err++; $display("FAIL null_byte c%0d got %b%b %h want %b%b %h", c, data_out_req, data_in_ack, data_out, exp_req, exp_ack, exp_out);
            end
            half_b();
        end
        n_cmp++;
        if (null_pkt_cnt !== 16'(m_null) || m_null != 2) begin
            n_err++; $display("FAIL null_cnt got %0d want 2", null_pkt_cnt);
        end
    endtask

    task automatic test_src_during_null();
        int idx;
        int guard;
        data_in_req = 1'b0; null_en = 1'b1; data_out_ack = 1'b1;
        guard = 0;
        while (!(m_in_pkt && m_is_null && m_pos == 50) && guard < 300) begin
            half_a(); half_b(); guard++;
        end
        idx = 0; guard = 0;
        while (idx < 188 && guard < 600) begin
            data_in_req = 1'b1;
            data_in     = (idx == 0) ? 8'h47 : 8'(idx);
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack} !== {exp_req, exp_ack}) begin
                n_err++; $display("FAIL preempt_hs g%0d got %b%b want %b%b", guard, data_out_req, data_in_ack, exp_req, exp_ack);
            end
            if (exp_chk_out) begin
                n_cmp++;
                if (data_out !== exp_out) begin
                    n_err++; $display("FAIL preempt_byte g%0d got %h want %h", guard, data_out, exp_out);
                end
            end
            half_b();
            if (exp_ack) idx++;
            guard++;
        end
        data_in_req = 1'b0; null_en = 1'b0;
        n_cmp++;
        if (idx != 188 || null_pkt_cnt !== 16'(m_null) || src_pkt_cnt !== 16'(m_src) || m_null != 3) begin
            n_err++; $display("FAIL preempt_cnt got null=%0d src=%0d idx=%0d want null=3 src=%0d", null_pkt_cnt, src_pkt_cnt, idx, m_src);
        end
    endtask

    task automatic test_drop();
        int idx;
        int guard;
        null_en = 1'b0; data_out_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in_req = 1'b1; data_in = 8'h00;
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack} !== 2'b01) begin
                n_err++; $display("FAIL drop_hs b%0d got req=%b ack=%b want 0 1", i, data_out_req, data_in_ack);
            end
            half_b();
        end
        idx = 0; guard = 0;
        while (idx < 188 && guard < 400) begin
            data_in_req = 1'b1;
            data_in     = (idx == 0) ? 8'h47 : 8'(idx);
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack, data_out} !== {exp_req, exp_ack, exp_out}) begin
                n_err++; $display("FAIL drop_pkt b%0d got %b%b %h want %b%b %h", idx, data_out_req, data_in_ack, data_out, exp_req, exp_ack, exp_out);
            end
            half_b();
            if (exp_ack) idx++;
            guard++;
        end
        data_in_req = 1'b0;
        n_cmp++;
        if (drop_byte_cnt !== 16'(m_drop) || m_drop != 5 || src_pkt_cnt !== 16'(m_src)) begin
            n_err++; $display("FAIL drop_cnt got drop=%0d src=%0d want drop=5 src=%0d", drop_byte_cnt, src_pkt_cnt, m_src);
        end
    endtask

    task automatic test_stall();
        int idx;
        int stall;
        int guard;
        null_en = 1'b1; data_out_ack = 1'b1;
        idx = 0; stall = 0; guard = 0;
        while (idx < 188 && guard < 400) begin
            data_in_req = !(idx == 60 && stall < 10);
            data_in     = (idx == 0) ? 8'h47 : 8'(idx);
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack} !== {exp_req, exp_ack}) begin
                n_err++; $display("FAIL stall_hs b%0d s%0d got %b%b want %b%b", idx, stall, data_out_req, data_in_ack, exp_req, exp_ack);
            end
            if (exp_chk_out) begin
                n_cmp++;
                if (data_out !== exp_out) begin
                    n_err++; $display("FAIL stall_byte b%0d got %h want %h", idx, data_out, exp_out);
                end
            end
            half_b();
            if (!data_in_req) stall++;
            if (exp_ack) idx++;
            guard++;
        end
        null_en = 1'b0; data_in_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack, data_out} !== {1'b0, 1'b0, 8'h00}) begin
                n_err++; $display("FAIL idle_out c%0d got %b%b %h want 00 00", c, data_out_req, data_in_ack, data_out);
            end
            half_b();
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        int guard;
        null_en = 1'b0; data_out_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data_in_req = 1'b1;
            data_in     = (i == 0) ? 8'h47 : 8'(i);
            half_a(); half_b();
        end
        data_in_req = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        n_cmp++;
        if ({src_pkt_cnt, null_pkt_cnt, drop_byte_cnt} !== 48'd0 || data_out_req !== 1'b0) begin
            n_err++; $display("FAIL midreset got cnt=%0d/%0d/%0d req=%b want 0/0/0 req=0", src_pkt_cnt, null_pkt_cnt, drop_byte_cnt, data_out_req);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        idx = 0; guard = 0;
        while (idx < 188 && guard < 400) begin
            data_in_req = 1'b1;
            data_in     = (idx == 0) ? 8'h47 : 8'(idx + 3);
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack, data_out} !== {exp_req, exp_ack, exp_out}) begin
                n_err++; $display("FAIL midreset_pkt b%0d got %b%b %h want %b%b %h", idx, data_out_req, data_in_ack, data_out, exp_req, exp_ack, exp_out);
            end
            half_b();
            if (exp_ack) idx++;
            guard++;
        end
        data_in_req = 1'b0;
        n_cmp++;
        if (src_pkt_cnt !== 16'd1 || m_src != 1) begin
            n_err++; $display("FAIL midreset_cnt got %0d want 1", src_pkt_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] src_q [$];
        logic [7:0] b;
        for (int c = 0; c < 4000; c++) begin
            if (src_q.size() == 0) begin
                if ($urandom_range(3) == 0) begin
                    for (int j = 0; j <= int'($urandom_range(2)); j++) begin
                        b = 8'($urandom);
                        if (b == 8'h47) b = 8'h00;
                        src_q.push_back(b);
                    end
                end else begin
                    src_q.push_back(8'h47);
                    for (int j = 1; j < 188; j++) src_q.push_back(8'($urandom));
                end
            end
            if (c % 50 == 0) null_en = 1'($urandom);
            data_in_req  = ($urandom_range(7) != 0);
            data_in      = data_in_req ? src_q[0] : 8'($urandom);
            data_out_ack = ($urandom_range(3) != 0);
            half_a();
            n_cmp++;
            if ({data_out_req, data_in_ack} !== {exp_req, exp_ack}) begin
                n_err++; $display("FAIL rand_hs c%0d got %b%b want %b%b", c, data_out_req, data_in_ack, exp_req, exp_ack);
            end
            if (exp_chk_out) begin
                n_cmp++;
                if (data_out !== exp_out) begin
                    n_err++; $display("FAIL rand_byte c%0d got %h want %h", c, data_out, exp_out);
                end
            end
            half_b();
            if (data_in_req && exp_ack) void'(src_q.pop_front());
        end
        n_cmp++;
        if ({src_pkt_cnt, null_pkt_cnt, drop_byte_cnt} !== {16'(m_src), 16'(m_null), 16'(m_drop)}) begin
            n_err++; $display("FAIL rand_cnt got %0d/%0d/%0d want %0d/%0d/%0d", src_pkt_cnt, null_pkt_cnt, drop_byte_cnt, m_src, m_null, m_drop);
        end
    endtask

    initial begin
        for (int i = 0; i < 188; i++) null_ref[i] = 8'hFF;
        null_ref[0] = 8'h47;
        null_ref[1] = 8'h1F;
        null_ref[2] = 8'hFF;
        null_ref[3] = 8'h10;
        test_reset();
        test_src_packets();
        test_null_packets();
        test_src_during_null();
        test_drop();
        test_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
